bnnroll_sample_sequencer: RTL and testbench
===========================================

Name: bnnroll_sample_sequencer

Overview:
- Hardware initiator for the rolled BNN cores (e.g. pendigits_bnn1_bnnroll); it is the driving end of the features/rst/prediction interface.
- Fetches TEST_CNT packed samples from a 1-cycle-latency sample ROM and presents each to the core with a one-cycle core reset.
- Waits a fixed compute window, captures the prediction, and emits {index, prediction} on a valid/ready result stream.
- Replaces bench-only sequencing for on-chip / FPGA self-test.

Parameters:
- FEAT_CNT, 16, features per sample
- FEAT_BITS, 4, bits per feature
- HIDDEN_CNT, 40, hidden neurons of the attached core
- CLASS_CNT, 10, number of classes
- TEST_CNT, 1000, samples per run; must be >= 1
- WAIT_CYCLES, 2*HIDDEN_CNT+1, core compute cycles after core_rst deasserts; must be >= 1
- Derived: CLASS_BITS=$clog2(CLASS_CNT), IDX_BITS=$clog2(TEST_CNT), SAMPLE_W=FEAT_BITS*FEAT_CNT

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  1-cycle pulse; begins a run when idle
- busy  out  1  high from the cycle after accepted start until the cycle done pulses
- done  out  1  1-cycle pulse after the last result handshake
- mem_rd  out  1  sample ROM read strobe
- mem_addr  out  IDX_BITS  sample ROM address
- mem_data  in  SAMPLE_W  ROM data, valid the cycle after mem_rd
- features  out  SAMPLE_W  to core features
- core_rst  out  1  to core rst
- prediction  in  CLASS_BITS  from core
- res_valid  out  1  result valid
- res_ready  in  1  result accepted
- res_data  out  IDX_BITS+CLASS_BITS  {sample index, prediction}

Behaviour:
- All outputs registered.
- Reset values: busy=0, done=0, mem_rd=0, mem_addr=0, features=0, core_rst=1, res_valid=0, res_data=0; state IDLE; index=0; wait counter=0.
- FSM states: IDLE, FETCH, LOAD, CRST, RUN, EMIT.
- IDLE:
  - core_rst=1.
  - start=1 -> index=0 and go to FETCH.
  - start is ignored in every other state.
- FETCH (1 cycle): mem_rd=1, mem_addr=index -> LOAD.
- LOAD (1 cycle): mem_rd=0; features<=mem_data at the end of the cycle -> CRST.
- CRST (1 cycle):
  - core_rst=1 while features are stable.
  - Load counter=WAIT_CYCLES-1 -> RUN.
- RUN:
  - core_rst=0; counter decrements each cycle.
  - When counter==0 (WAIT_CYCLES cycles spent in RUN), register res_data={index, prediction}, set res_valid=1 -> EMIT.
- EMIT:
  - res_valid and res_data held stable until res_valid&&res_ready.
  - core_rst stays 0 and features are unchanged.
  - On handshake: res_valid=0.
    - If index==TEST_CNT-1: done=1 for one cycle, busy=0 -> IDLE.
    - Otherwise index+1 -> FETCH.
- Per-sample latency with res_ready tied high: 1 (FETCH) + 1 (LOAD) + 1 (CRST) + WAIT_CYCLES (RUN) + 1 (EMIT) = WAIT_CYCLES+4 cycles.
- TEST_CNT=1: one result, then done. The index never wraps; the run ends at TEST_CNT-1.
- Backpressure: arbitrary res_ready stalls hold EMIT indefinitely, with no loss or duplication.
- rst mid-run:
  - Next cycle, all outputs return to reset values and state is IDLE.
  - A pending result is dropped; no done pulse.
- rst and start asserted together: rst wins.
- start in the same cycle as the done pulse (already IDLE): accepted; a new run begins.

Optional Feature:
- Macro: BNNROLL_SCORE_EN.
- Defined:
  - Adds input mem_label [CLASS_BITS-1:0], valid alongside mem_data and captured in LOAD.
  - Adds output correct_cnt [$clog2(TEST_CNT+1)-1:0]: cleared to 0 on accepted start and on rst; increments on each EMIT handshake where the captured prediction == label; holds after done.
- Undefined: neither port exists and there is no scoring logic; all other behaviour is identical.

Test Plan:
- TEST_CNT=4, WAIT_CYCLES=81, stub core predicting features[3:0] mod 10, res_ready=1 -> res_data indices 0,1,2,3 with the correct predictions; 85 cycles per sample; done pulses once, 340 cycles after start accepted.
- Check core handshake -> core_rst high for exactly 1 cycle per sample with features already equal to ROM[index]; mem_addr=index during the mem_rd cycle.
- res_ready low for 10 cycles during EMIT of sample 2 -> res_valid and res_data stable throughout; exactly 4 results; no duplicates.
- rst asserted during RUN of sample 1 -> next cycle busy=0, core_rst=1, res_valid=0; no done pulse; a fresh start yields index 0 first.
- start pulsed while busy, and TEST_CNT=1 run -> mid-run start has no effect; single-sample run emits index 0, then done.
- BNNROLL_SCORE_EN defined, labels matching the stub predictions for 3 of 4 samples -> correct_cnt=3 at done; reset to 0 on the next start.

Source files
------------

// File: rtl/bnnroll_sample_sequencer_if.sv
// Bundles the sequencer's control, sample-ROM, core and result-stream signals.
// The scoring port pair is present only when BNNROLL_SCORE_EN is defined.
interface bnnroll_sample_sequencer_if #(
    parameter int unsigned FEAT_CNT  = 16,
    parameter int unsigned FEAT_BITS = 4,
    parameter int unsigned CLASS_CNT = 10,
    parameter int unsigned TEST_CNT  = 1000
);
    localparam int unsigned CLASS_BITS = (CLASS_CNT > 1) ? $clog2(CLASS_CNT) : 1;
    localparam int unsigned IDX_BITS   = (TEST_CNT > 1) ? $clog2(TEST_CNT) : 1;
    localparam int unsigned SAMPLE_W   = FEAT_BITS * FEAT_CNT;

    logic                           start;
    logic                           busy;
    logic                           done;
    logic                           mem_rd;
    logic [IDX_BITS-1:0]            mem_addr;
    logic [SAMPLE_W-1:0]            mem_data;
    logic [SAMPLE_W-1:0]            features;
    logic                           core_rst;
    logic [CLASS_BITS-1:0]          prediction;
    logic                           res_valid;
    logic                           res_ready;
    logic [IDX_BITS+CLASS_BITS-1:0] res_data;
`ifdef BNNROLL_SCORE_EN
    localparam int unsigned SCORE_BITS = $clog2(TEST_CNT + 1);
    logic [CLASS_BITS-1:0]          mem_label;
    logic [SCORE_BITS-1:0]          correct_cnt;

    modport master (
        input  start, mem_data, prediction, res_ready, mem_label,
        output busy, done, mem_rd, mem_addr, features, core_rst, res_valid, res_data, correct_cnt
    );
    modport slave (
        output start, mem_data, prediction, res_ready, mem_label,
        input  busy, done, mem_rd, mem_addr, features, core_rst, res_valid, res_data, correct_cnt
    );
`else
    modport master (
        input  start, mem_data, prediction, res_ready,
        output busy, done, mem_rd, mem_addr, features, core_rst, res_valid, res_data
    );
    modport slave (
        output start, mem_data, prediction, res_ready,
        input  busy, done, mem_rd, mem_addr, features, core_rst, res_valid, res_data
    );
`endif
endinterface

// File: rtl/bnnroll_sample_sequencer.sv
// Drives a rolled BNN core through TEST_CNT ROM samples and streams {index, prediction}.
// Optional label scoring (mem_label / correct_cnt) is enabled by BNNROLL_SCORE_EN.
module bnnroll_sample_sequencer #(
    parameter int unsigned FEAT_CNT    = 16,
    parameter int unsigned FEAT_BITS   = 4,
    parameter int unsigned HIDDEN_CNT  = 40,
    parameter int unsigned CLASS_CNT   = 10,
    parameter int unsigned TEST_CNT    = 1000,
    parameter int unsigned WAIT_CYCLES = 2 * HIDDEN_CNT + 1
) (
    input logic                        clk,
    input logic                        rst,
    bnnroll_sample_sequencer_if.master bus
);
    localparam int unsigned CLASS_BITS = (CLASS_CNT > 1) ? $clog2(CLASS_CNT) : 1;
    localparam int unsigned IDX_BITS   = (TEST_CNT > 1) ? $clog2(TEST_CNT) : 1;
    localparam int unsigned SAMPLE_W   = FEAT_BITS * FEAT_CNT;
    localparam int unsigned RES_W      = IDX_BITS + CLASS_BITS;
    localparam int unsigned CNT_BITS   = $clog2(WAIT_CYCLES + 1);
    localparam logic [IDX_BITS-1:0] LAST_IDX  = IDX_BITS'(TEST_CNT - 1);
    localparam logic [CNT_BITS-1:0] CNT_START = CNT_BITS'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, CRST, RUN, EMIT} state_t;

    state_t              state_q, state_d;
    logic [IDX_BITS-1:0] index_q, index_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                mem_rd_q, mem_rd_d;
    logic [IDX_BITS-1:0] mem_addr_q, mem_addr_d;
    logic [SAMPLE_W-1:0] features_q, features_d;
    logic                core_rst_q, core_rst_d;
    logic                res_valid_q, res_valid_d;
    logic [RES_W-1:0]    res_data_q, res_data_d;
`ifdef BNNROLL_SCORE_EN
    localparam int unsigned SCORE_BITS = $clog2(TEST_CNT + 1);
    logic [CLASS_BITS-1:0] label_q, label_d;
    logic [SCORE_BITS-1:0] correct_q, correct_d;
`endif

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            index_q     <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            features_q  <= '0;
            core_rst_q  <= 1'b1;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
`ifdef BNNROLL_SCORE_EN
            label_q     <= '0;
            correct_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mem_rd_q    <= mem_rd_d;
            mem_addr_q  <= mem_addr_d;
            features_q  <= features_d;
            core_rst_q  <= core_rst_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
`ifdef BNNROLL_SCORE_EN
            label_q     <= label_d;
            correct_q   <= correct_d;
`endif
        end
    end

    // Next state and next output values; outputs are set on entry to the state that shows them
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        mem_rd_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        features_d  = features_q;
        core_rst_d  = core_rst_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
`ifdef BNNROLL_SCORE_EN
        label_d     = label_q;
        correct_d   = correct_q;
`endif
        unique case (state_q)
            IDLE: begin
                core_rst_d = 1'b1;
                if (bus.start) begin
                    index_d    = '0;
                    busy_d     = 1'b1;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = '0;
                    core_rst_d = 1'b0;
                    state_d    = FETCH;
`ifdef BNNROLL_SCORE_EN
                    correct_d  = '0;
`endif
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                features_d = bus.mem_data;
                core_rst_d = 1'b1;
`ifdef BNNROLL_SCORE_EN
                label_d    = bus.mem_label;
`endif
                state_d    = CRST;
            end
            CRST: begin
                cnt_d      = CNT_START;
                core_rst_d = 1'b0;
                state_d    = RUN;
            end
            RUN: begin
                if (cnt_q == '0) begin
                    res_data_d  = {index_q, bus.prediction};
                    res_valid_d = 1'b1;
                    state_d     = EMIT;
                end else begin
                    cnt_d = cnt_q - CNT_BITS'(1);
                end
            end
            EMIT: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
`ifdef BNNROLL_SCORE_EN
                    if (res_data_q[CLASS_BITS-1:0] == label_q)
                        correct_d = correct_q + SCORE_BITS'(1);
`endif
                    if (index_q == LAST_IDX) begin
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        core_rst_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        index_d    = index_q + IDX_BITS'(1);
                        mem_rd_d   = 1'b1;
                        mem_addr_d = index_q + IDX_BITS'(1);
                        state_d    = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.features  = features_q;
    assign bus.core_rst  = core_rst_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
`ifdef BNNROLL_SCORE_EN
    assign bus.correct_cnt = correct_q;
`endif
endmodule

// File: tb/tb_bnnroll_sample_sequencer.sv
// Directed bench for bnnroll_sample_sequencer: 4-sample run with a stub core, backpressure,
// mid-run reset, restart on done and a 1-sample instance. Score checks under BNNROLL_SCORE_EN.
module tb_bnnroll_sample_sequencer;
    typedef struct {
        logic [63:0] word;
        logic [3:0]  label;
        logic [5:0]  exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    vec_t tab [4];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    bnnroll_sample_sequencer_if #(.FEAT_CNT(16), .FEAT_BITS(4), .CLASS_CNT(10), .TEST_CNT(4)) bus ();
    bnnroll_sample_sequencer_if #(.FEAT_CNT(16), .FEAT_BITS(4), .CLASS_CNT(10), .TEST_CNT(1)) bus1 ();

    bnnroll_sample_sequencer #(.TEST_CNT(4), .WAIT_CYCLES(81)) dut (.clk(clk), .rst(rst), .bus(bus));
    bnnroll_sample_sequencer #(.TEST_CNT(1), .WAIT_CYCLES(5)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // Stub cores and 1-cycle-latency ROMs
    assign bus.prediction  = 4'(bus.features[3:0] % 4'd10);
    assign bus1.prediction = 4'(bus1.features[3:0] % 4'd10);
    always @(posedge clk) begin
        if (bus.mem_rd) begin
            bus.mem_data <= tab[bus.mem_addr].word;
`ifdef BNNROLL_SCORE_EN
            bus.mem_label <= tab[bus.mem_addr].label;
`endif
        end
        if (bus1.mem_rd) begin
            bus1.mem_data <= 64'hAAAA_AAAA_AAAA_AAA9;
`ifdef BNNROLL_SCORE_EN
            bus1.mem_label <= 4'd9;
`endif
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: ROM address, single-cycle core reset, EMIT stability, result capture
    logic [5:0] res_q [$];
    int         stamp_q [$];
    int         crst_cnt = 0;
    logic       prv_valid = 1'b0, prv_hs = 1'b0, prv_rst = 1'b1, prv_crst = 1'b1;
    logic [5:0] prv_data = '0;
    int         ci;

    always @(negedge clk) begin
        ci = res_q.size();
        if (bus.mem_rd) check("mem_addr", 64'(bus.mem_addr), 64'(ci));
        if (bus.busy && bus.core_rst) begin
            crst_cnt++;
            check("crst_single", 64'(prv_crst), 64'(0));
            if (ci < 4) check("crst_features", bus.features, tab[ci].word);
        end
        if (prv_valid && !prv_hs && !prv_rst) begin
            check("valid_hold", 64'(bus.res_valid), 64'(1));
            check("data_hold", 64'(bus.res_data), 64'(prv_data));
        end
        if (bus.res_valid && bus.res_ready && !rst) begin
            res_q.push_back(bus.res_data);
            stamp_q.push_back(cyc);
        end
        prv_valid = bus.res_valid;
        prv_hs    = bus.res_valid & bus.res_ready;
        prv_rst   = rst;
        prv_crst  = bus.core_rst;
        prv_data  = bus.res_data;
    end

    task automatic clear_run();
        res_q.delete();
        stamp_q.delete();
        crst_cnt = 0;
    endtask

    task automatic check_results(input string tag);
        check({tag, "_count"}, 64'(res_q.size()), 64'(4));
        for (int i = 0; i < 4; i++)
            if (i < res_q.size()) check({tag, "_data"}, 64'(res_q[i]), 64'(tab[i].exp));
    endtask

    initial begin
        int n, stall, hs, seen;
        logic [4:0] d1;
        tab[0] = '{64'h0123_4567_89AB_CDE3, 4'd3, 6'h03};
        tab[1] = '{64'hFEDC_BA98_7654_321C, 4'd2, 6'h12};
        tab[2] = '{64'h5A5A_5A5A_5A5A_5A57, 4'd0, 6'h27};
        tab[3] = '{64'h0F0F_0F0F_0F0F_0F0F, 4'd5, 6'h35};
        bus.start = 1'b0;  bus.res_ready = 1'b1;
        bus1.start = 1'b0; bus1.res_ready = 1'b1;
        rst = 1'b1;
        tick(3);

        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_mem_rd", 64'(bus.mem_rd), 64'(0));
        check("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
        check("rst_features", bus.features, 64'(0));
        check("rst_core_rst", 64'(bus.core_rst), 64'(1));
        check("rst_res_valid", 64'(bus.res_valid), 64'(0));
        check("rst_res_data", 64'(bus.res_data), 64'(0));

        // rst and start together: rst wins
        bus.start = 1'b1; tick(); bus.start = 1'b0; rst = 1'b0; tick();
        check("rst_wins_busy", 64'(bus.busy), 64'(0));
        check("rst_wins_mem_rd", 64'(bus.mem_rd), 64'(0));

        // Single-sample instance
        bus1.start = 1'b1; tick(); bus1.start = 1'b0;
        n = 0; hs = 0; d1 = '0;
        while (!bus1.done && n < 200) begin
            if (bus1.res_valid && bus1.res_ready) begin hs++; d1 = bus1.res_data; end
            tick(); n++;
        end
        check("one_latency", 64'(n), 64'(9));
        check("one_hs", 64'(hs), 64'(1));
        check("one_data", 64'(d1), 64'(5'h09));
`ifdef BNNROLL_SCORE_EN
        check("one_score", 64'(bus1.correct_cnt), 64'(1));
`endif
        tick();
        check("one_done_pulse", 64'(bus1.done), 64'(0));

        // Run 1: ready high, stray start mid-run
        clear_run();
        bus.start = 1'b1; tick(); bus.start = 1'b0; n = 0;
        check("run1_busy", 64'(bus.busy), 64'(1));
        check("run1_mem_rd", 64'(bus.mem_rd), 64'(1));
        while (!bus.done && n < 2000) begin
            bus.start = (n == 100); tick(); n++;
        end
        bus.start = 1'b0;
        check("run1_latency", 64'(n), 64'(340));
        check("run1_busy_at_done", 64'(bus.busy), 64'(0));
`ifdef BNNROLL_SCORE_EN
        check("run1_score", 64'(bus.correct_cnt), 64'(3));
`endif
        tick();
        check("run1_done_pulse", 64'(bus.done), 64'(0));
        check_results("run1");
        for (int i = 1; i < 4; i++)
            if (i < stamp_q.size()) check("run1_spacing", 64'(stamp_q[i] - stamp_q[i-1]), 64'(85));
        check("run1_crst", 64'(crst_cnt), 64'(4));

        // Run 2: 10-cycle stall during EMIT of sample 2
        clear_run();
        stall = 0;
        bus.start = 1'b1; tick(); bus.start = 1'b0; n = 0;
`ifdef BNNROLL_SCORE_EN
        check("run2_score_clr", 64'(bus.correct_cnt), 64'(0));
`endif
        while (!bus.done && n < 2000) begin
            if (bus.res_valid && bus.res_data[5:4] == 2'd2 && stall < 10) begin
                bus.res_ready = 1'b0; stall++;
            end else begin
                bus.res_ready = 1'b1;
            end
            tick(); n++;
        end
        bus.res_ready = 1'b1;
        check("run2_latency", 64'(n), 64'(350));
        check("run2_stall", 64'(stall), 64'(10));
        check_results("run2");
        tick();

        // Run 3: rst during RUN of sample 1
        clear_run();
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        tick(100);
        check("pre_rst_core_rst", 64'(bus.core_rst), 64'(0));
        rst = 1'b1; tick(); rst = 1'b0;
        check("mid_rst_busy", 64'(bus.busy), 64'(0));
        check("mid_rst_core_rst", 64'(bus.core_rst), 64'(1));
        check("mid_rst_valid", 64'(bus.res_valid), 64'(0));
        check("mid_rst_features", bus.features, 64'(0));
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (bus.done) seen = 1;
        end
        check("mid_rst_no_done", 64'(seen), 64'(0));
        check("mid_rst_results", 64'(res_q.size()), 64'(1));

        // Fresh run after reset, then restart in the done cycle
        clear_run();
        bus.start = 1'b1; tick(); bus.start = 1'b0; n = 0;
        while (!bus.done && n < 2000) begin tick(); n++; end
        check("run4_latency", 64'(n), 64'(340));
        check_results("run4");
        clear_run();
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        check("restart_busy", 64'(bus.busy), 64'(1));
        check("restart_mem_rd", 64'(bus.mem_rd), 64'(1));
        n = 0;
        while (!bus.done && n < 2000) begin tick(); n++; end
        check("run5_latency", 64'(n), 64'(340));
        check_results("run5");
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
